// File: rtl/athena_vreg_pkg.sv
// Shared types and constants for the video-register write arbiter.
// States, target address map, latched request record and strobe decode.
package athena_vreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } vreg_state_t;

  localparam logic [1:0] VREG_MSB  = 2'd0;
  localparam logic [1:0] VREG_FSY  = 2'd1;
  localparam logic [1:0] VREG_COIN = 2'd2;
  localparam logic [1:0] VREG_RSVD = 2'd3;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } vreg_req_t;

  // Strobe vector ordered {COIN_COUNTERS, FSY, MSB}; the reserved address strobes nothing.
  function automatic logic [2:0] vreg_decode(input logic [1:0] addr);
    logic [2:0] strobe;
    strobe = 3'b000;
    case (addr)
      VREG_MSB:  strobe = 3'b001;
      VREG_FSY:  strobe = 3'b010;
      VREG_COIN: strobe = 3'b100;
      default:   strobe = 3'b000;
    endcase
    return strobe;
  endfunction

endpackage

// File: rtl/athena_vreg_write_arbiter_rr.sv
// Two-requester round-robin grant (main vs sub) with a registered last-grant pointer.
// The grant is only offered while the write sequencer is idle.
module athena_rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic m_req_i,
  input  logic s_req_i,
  input  logic upd_i,
  input  logic upd_sub_i,
  output logic gnt_o,
  output logic gnt_sub_o
);

  // Reset value "sub was last" makes main win the first contested grant.
  logic last_sub_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_sub_q <= 1'b1;
    end else if (upd_i) begin
      last_sub_q <= upd_sub_i;
    end
  end

  always_comb begin
    gnt_o     = en_i && (m_req_i || s_req_i);
    gnt_sub_o = s_req_i && (!m_req_i || !last_sub_q);
  end

endmodule

// File: rtl/athena_vreg_write_arbiter.sv
// Shares the VD byte bus and register strobes between main and sub CPU, sequencing
// every write as setup, one strobe cycle, hold, then a one-cycle acknowledge.
module athena_vreg_write_arbiter
  import athena_vreg_pkg::*;
#(
  parameter int HOLD_CYCLES  = 1,
  parameter int SETUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        VIDEO_RSTn,
  input  logic        m_req,
  input  logic [1:0]  m_addr,
  input  logic [7:0]  m_data,
  output logic        m_ack,
  input  logic        s_req,
  input  logic [1:0]  s_addr,
  input  logic [7:0]  s_data,
  output logic        s_ack,
  output logic [7:0]  VD_out,
  output logic        MSB,
  output logic        FSY,
  output logic        COIN_COUNTERS,
  output logic        busy,
  output logic        bad_addr,
  output vreg_state_t dbg_state_o
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 7) begin : g_bad_setup
    $error("SETUP_CYCLES must be in 1..7");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 7) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..7");
  end

  localparam logic [2:0] SETUP_LOAD = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] HOLD_LOAD  = 3'(HOLD_CYCLES - 1);

  // Handshake: a requester raises req with addr/data and holds req until it samples
  // its ack high for one cycle; addr/data are captured only at the grant edge.
  vreg_state_t state_q;
  logic [2:0]  cnt_q;
  vreg_req_t   req_q;
  logic        sub_q;
  logic [7:0]  vd_q;
  logic [2:0]  strobe_q;
  logic        m_ack_q, s_ack_q, bad_q, busy_q;
  logic        gnt, gnt_sub;

  athena_rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_ni    (VIDEO_RSTn),
    .en_i      (state_q == IDLE),
    .m_req_i   (m_req),
    .s_req_i   (s_req),
    .upd_i     (state_q == DONE),
    .upd_sub_i (sub_q),
    .gnt_o     (gnt),
    .gnt_sub_o (gnt_sub)
  );

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      sub_q    <= 1'b0;
      vd_q     <= '0;
      strobe_q <= '0;
      m_ack_q  <= 1'b0;
      s_ack_q  <= 1'b0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= '0;
      m_ack_q  <= 1'b0;
      s_ack_q  <= 1'b0;
      bad_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt) begin
            req_q   <= gnt_sub ? {s_addr, s_data} : {m_addr, m_data};
            vd_q    <= gnt_sub ? s_data : m_data;
            sub_q   <= gnt_sub;
            cnt_q   <= SETUP_LOAD;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 3'd0) begin
            strobe_q <= vreg_decode(req_q.addr);
            state_q  <= STROBE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        STROBE: begin
          cnt_q   <= HOLD_LOAD;
          state_q <= HOLD;
        end
        HOLD: begin
          if (cnt_q == 3'd0) begin
            m_ack_q <= !sub_q;
            s_ack_q <= sub_q;
            bad_q   <= (req_q.addr == VREG_RSVD);
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // VD_out is never cleared between writes; only reset zeroes it.
  assign VD_out        = vd_q;
  assign MSB           = strobe_q[0];
  assign FSY           = strobe_q[1];
  assign COIN_COUNTERS = strobe_q[2];
  assign m_ack         = m_ack_q;
  assign s_ack         = s_ack_q;
  assign bad_addr      = bad_q;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_athena_vreg_write_arbiter.sv
// Randomized scoreboard bench for the video-register write arbiter, plus a directed
// pass on a second instance with SETUP_CYCLES=3, HOLD_CYCLES=2.
module tb_athena_vreg_write_arbiter;
  import athena_vreg_pkg::*;

  localparam int B_SETUP = 3;
  localparam int B_HOLD  = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A (default timing)
  logic       m_req = 1'b0, s_req = 1'b0;
  logic [1:0] m_addr = '0, s_addr = '0;
  logic [7:0] m_data = '0, s_data = '0;
  logic       m_ack, s_ack, msb, fsy, coin, busy, bad;
  logic [7:0] vd;
  vreg_state_t dbg;

  athena_vreg_write_arbiter u_dut (
    .clk(clk), .VIDEO_RSTn(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_data(m_data), .m_ack(m_ack),
    .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_ack(s_ack),
    .VD_out(vd), .MSB(msb), .FSY(fsy), .COIN_COUNTERS(coin),
    .busy(busy), .bad_addr(bad), .dbg_state_o(dbg)
  );

  // DUT B (stretched timing)
  logic       bm_req = 1'b0, bs_req = 1'b0;
  logic [1:0] bm_addr = '0, bs_addr = '0;
  logic [7:0] bm_data = '0, bs_data = '0;
  logic       bm_ack, bs_ack, bmsb, bfsy, bcoin, bbusy, bbad;
  logic [7:0] bvd;
  vreg_state_t bdbg;

  athena_vreg_write_arbiter #(.HOLD_CYCLES(B_HOLD), .SETUP_CYCLES(B_SETUP)) u_dut_b (
    .clk(clk), .VIDEO_RSTn(rst_n),
    .m_req(bm_req), .m_addr(bm_addr), .m_data(bm_data), .m_ack(bm_ack),
    .s_req(bs_req), .s_addr(bs_addr), .s_data(bs_data), .s_ack(bs_ack),
    .VD_out(bvd), .MSB(bmsb), .FSY(bfsy), .COIN_COUNTERS(bcoin),
    .busy(bbusy), .bad_addr(bbad), .dbg_state_o(bdbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model + scoreboard: entries are {side(1=sub), addr, data}
  logic [10:0] exp_q[$];
  logic [10:0] cur;
  int          k = 0;          // cycles since grant, 0 = idle
  logic        last_sub = 1'b1;
  logic [7:0]  vd_model = '0;
  logic        smp_rst = 1'b0, smp_m = 1'b0, smp_s = 1'b0, side;
  logic [1:0]  smp_ma = '0, smp_sa = '0;
  logic [7:0]  smp_md = '0, smp_sd = '0;

  function automatic logic [2:0] exp_strobe(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      k = 0;
      last_sub = 1'b1;
      vd_model = '0;
      exp_q.delete();
      check("reset_outputs", {busy, msb, fsy, coin, m_ack, s_ack, bad}, 0);
      check("reset_vd", vd, 0);
      check("reset_state", dbg, IDLE);
    end else begin
      if (k == 0) begin
        if (smp_rst && (smp_m || smp_s)) begin
          side = (smp_m && smp_s) ? !last_sub : smp_s;
          last_sub = side;
          exp_q.push_back(side ? {1'b1, smp_sa, smp_sd} : {1'b0, smp_ma, smp_md});
          vd_model = side ? smp_sd : smp_md;
          k = 1;
        end
      end else if (k == 4) begin
        k = 0;
      end else begin
        k = k + 1;
      end
      cur = (k != 0) ? exp_q[0] : '0;
      check("busy", busy, (k != 0));
      check("vd_out", vd, vd_model);
      check("strobes", {coin, fsy, msb}, (k == 2) ? exp_strobe(cur[9:8]) : 3'b000);
      if (k == 0) check("idle_state", dbg, IDLE);
      if (k == 4) begin
        cur = exp_q.pop_front();
        check("ack_side", {s_ack, m_ack}, cur[10] ? 2'b10 : 2'b01);
        check("bad_addr", bad, (cur[9:8] == 2'd3));
      end else begin
        check("no_ack", {bad, s_ack, m_ack}, 0);
      end
    end
    smp_rst = rst_n;
    smp_m = m_req;  smp_ma = m_addr;  smp_md = m_data;
    smp_s = s_req;  smp_sa = s_addr;  smp_sd = s_data;
  end

  // driver tasks (inputs change only at posedge+1)
  task automatic set_req(input logic sd, input logic [1:0] a, input logic [7:0] d);
    if (sd) begin s_req = 1'b1; s_addr = a; s_data = d; end
    else    begin m_req = 1'b1; m_addr = a; m_data = d; end
  endtask

  task automatic drop(input logic sd);
    if (sd) s_req = 1'b0;
    else    m_req = 1'b0;
  endtask

  task automatic issue(input logic sd, input logic [1:0] a, input logic [7:0] d, input bit jitter);
    bit got;
    int n;
    set_req(sd, a, d);
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = sd ? s_ack : m_ack;
      @(posedge clk); #1;
      n++;
      if (!got && jitter && ($urandom_range(0, 1) == 1))
        set_req(sd, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    check("ack_seen", got, 1'b1);
  endtask

  task automatic rand_thread(input logic sd, input int n);
    for (int i = 0; i < n; i++) begin
      issue(sd, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 2) != 0) begin
        drop(sd);
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      end
    end
    drop(sd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_req = 1'b0; s_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // single main write to MSB
    issue(1'b0, VREG_MSB, 8'hA5, 1'b0);
    drop(1'b0);

    // simultaneous requests right after reset: main first
    do_reset();
    fork
      begin issue(1'b0, VREG_FSY, 8'h11, 1'b0);  drop(1'b0); end
      begin issue(1'b1, VREG_COIN, 8'h22, 1'b0); drop(1'b1); end
    join

    // both held for six transfers: strict alternation
    fork
      begin
        for (int i = 0; i < 3; i++) issue(1'b0, 2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 1'b0);
        drop(1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) issue(1'b1, 2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 1'b0);
        drop(1'b1);
      end
    join

    // reserved address from sub
    issue(1'b1, VREG_RSVD, 8'hFF, 1'b0);
    drop(1'b1);

    // randomized traffic with pre/post-grant input jitter
    fork
      rand_thread(1'b0, 25);
      rand_thread(1'b1, 25);
    join

    // reset asserted mid-STROBE
    repeat (2) begin @(posedge clk); #1; end
    set_req(1'b0, VREG_MSB, 8'h3C);
    @(posedge clk);
    @(posedge clk); #3;
    check("strobe_before_rst", {coin, fsy, msb}, 3'b001);
    rst_n = 1'b0;
    #1;
    check("rst_mid_strobe", {msb, fsy, coin, busy, m_ack, s_ack}, 0);
    check("rst_mid_vd", vd, 0);
    m_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      begin issue(1'b0, VREG_COIN, 8'h3C, 1'b0); drop(1'b0); end
      begin issue(1'b1, VREG_FSY, 8'hC3, 1'b0);  drop(1'b1); end
    join

    // DUT B: SETUP=3, HOLD=2, main to FSY
    repeat (2) begin @(posedge clk); #1; end
    bm_req = 1'b1; bm_addr = VREG_FSY; bm_data = 8'h5A;
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("b_busy", bbusy, (c <= B_SETUP + B_HOLD + 2));
      check("b_vd", bvd, 8'h5A);
      check("b_strobes", {bcoin, bfsy, bmsb}, (c == B_SETUP + 1) ? 3'b010 : 3'b000);
      check("b_acks", {bbad, bs_ack, bm_ack}, (c == B_SETUP + B_HOLD + 2) ? 3'b001 : 3'b000);
      @(posedge clk); #1;
      if (c == 2) bm_data = 8'hC3;
      if (c == B_SETUP + B_HOLD + 2) bm_req = 1'b0;
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
